// File: rtl/stateless_pkg.sv
// Shared definitions for the stateless ALU atoms.
//   opcode_e   : 4-bit ALU operation encoding (15 legal ops plus one illegal code)
//   sel_is_pkt : decides whether an operand-select value addresses a packet field
//                or falls through to the immediate constant
package stateless_pkg;

    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned NUM_OPNDS = 5;  // a, b, c1, c2, c3

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_AND     = 4'd2,
        OP_XOR     = 4'd3,
        OP_OR      = 4'd4,
        OP_EQ      = 4'd5,
        OP_NE      = 4'd6,
        OP_GE      = 4'd7,
        OP_LT      = 4'd8,
        OP_SHL     = 4'd9,
        OP_SHR     = 4'd10,
        OP_COND    = 4'd11,
        OP_MAX     = 4'd12,
        OP_MIN     = 4'd13,
        OP_SLT_S   = 4'd14,
        OP_ILLEGAL = 4'd15
    } opcode_e;

    // Select values at or beyond the field count route the constant instead.
    function automatic bit sel_is_pkt(input int unsigned sel_val, input int unsigned num_pkt);
        return sel_val < num_pkt;
    endfunction

endpackage

// File: rtl/stateless_alu_core.sv
// Purely combinational ALU core shared by the stateless and stateful atoms.
// Ports:
//   a_i, b_i          primary operands
//   c1_i, c2_i, c3_i  conditional-select operands (c1 != 0 ? c2 : c3)
//   opcode_i          operation, see stateless_pkg::opcode_e
//   result_o          result; 1-bit results are zero-extended
//   err_o             high for the illegal opcode (result forced to 0)
module stateless_alu_core
    import stateless_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [DATA_W-1:0]   c1_i,
    input  logic [DATA_W-1:0]   c2_i,
    input  logic [DATA_W-1:0]   c3_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [DATA_W-1:0]   result_o,
    output logic                err_o
);

    localparam logic [DATA_W-1:0] ShiftLimit = DATA_W'(DATA_W);

    // Shift amounts of DATA_W or more flush the operand to zero.
    logic shamt_ok;
    assign shamt_ok = b_i < ShiftLimit;

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (opcode_e'(opcode_i))
            OP_ADD:   result_o = a_i + b_i;
            OP_SUB:   result_o = a_i - b_i;
            OP_AND:   result_o = a_i & b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_EQ:    result_o = DATA_W'(a_i == b_i);
            OP_NE:    result_o = DATA_W'(a_i != b_i);
            OP_GE:    result_o = DATA_W'(a_i >= b_i);
            OP_LT:    result_o = DATA_W'(a_i < b_i);
            OP_SHL:   result_o = shamt_ok ? (a_i << b_i) : '0;
            OP_SHR:   result_o = shamt_ok ? (a_i >> b_i) : '0;
            OP_COND:  result_o = (c1_i != '0) ? c2_i : c3_i;
            OP_MAX:   result_o = (a_i >= b_i) ? a_i : b_i;
            OP_MIN:   result_o = (a_i <= b_i) ? a_i : b_i;
            OP_SLT_S: result_o = DATA_W'($signed(a_i) < $signed(b_i));
            default: begin
                result_o = '0;
                err_o    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/stateless_alu_pipe.sv
// Pipelined stateless ALU atom: operand muxing from NUM_PKT packet fields plus a
// constant, a combinational ALU core, and a 2-stage valid/ready elastic pipeline.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   in_valid, in_ready    request handshake
//   pkt, cons             packet fields (field i = pkt[i*DATA_W +: DATA_W]) and constant
//   opcode, sel           operation and five operand selects (a, b, c1, c2, c3)
//   out_valid, out_ready  result handshake
//   o_result, o_err       registered result and illegal-opcode flag
module stateless_alu_pipe
    import stateless_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_PKT = 3,
    // Derived from NUM_PKT; not meant to be overridden.
    parameter int unsigned SEL_W   = $clog2(NUM_PKT + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_PKT*DATA_W-1:0]     pkt,
    input  logic [DATA_W-1:0]             cons,
    input  logic [OPCODE_W-1:0]           opcode,
    input  logic [NUM_OPNDS*SEL_W-1:0]    sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             o_result,
    output logic                          o_err
);

    localparam int unsigned MuxEntries = 2 ** SEL_W;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_bin_t;

    typedef struct packed {
        logic [DATA_W-1:0] c1;
        logic [DATA_W-1:0] c2;
        logic [DATA_W-1:0] c3;
    } op_cond_t;

    typedef struct packed {
        op_bin_t             bin;
        op_cond_t            cond;
        logic [OPCODE_W-1:0] opcode;
    } s1_t;

    // Operand mux table padded to the full select range so every select value
    // indexes a real entry; out-of-range entries carry the constant.
    logic [DATA_W-1:0] mux_tbl [MuxEntries];
    logic [DATA_W-1:0] opnd    [NUM_OPNDS];

    for (genvar j = 0; j < MuxEntries; j++) begin : g_mux_tbl
        if (sel_is_pkt(j, NUM_PKT)) begin : g_field
            assign mux_tbl[j] = pkt[j*DATA_W +: DATA_W];
        end else begin : g_cons
            assign mux_tbl[j] = cons;
        end
    end

    for (genvar k = 0; k < NUM_OPNDS; k++) begin : g_opnd
        assign opnd[k] = mux_tbl[sel[k*SEL_W +: SEL_W]];
    end

    logic              s1_v_q, s1_v_d;
    s1_t               s1_q, s1_d;
    logic              s2_v_q, s2_v_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;

    logic              s2_ready;
    logic              accept;
    logic [DATA_W-1:0] core_result;
    logic              core_err;

    stateless_alu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .a_i      (s1_q.bin.a),
        .b_i      (s1_q.bin.b),
        .c1_i     (s1_q.cond.c1),
        .c2_i     (s1_q.cond.c2),
        .c3_i     (s1_q.cond.c3),
        .opcode_i (s1_q.opcode),
        .result_o (core_result),
        .err_o    (core_err)
    );

    always_comb begin
        s2_ready = !s2_v_q || out_ready;
        in_ready = !s1_v_q || s2_ready;
        accept   = in_valid && in_ready;

        // Stage 1: load on accept, otherwise empty out once stage 2 takes the entry.
        s1_v_d = s1_v_q;
        s1_d   = s1_q;
        if (accept) begin
            s1_v_d         = 1'b1;
            s1_d.bin.a     = opnd[0];
            s1_d.bin.b     = opnd[1];
            s1_d.cond.c1   = opnd[2];
            s1_d.cond.c2   = opnd[3];
            s1_d.cond.c3   = opnd[4];
            s1_d.opcode    = opcode;
        end else if (s2_ready) begin
            s1_v_d = 1'b0;
        end

        // Stage 2: only advances when free or draining; data is held otherwise.
        s2_v_d   = s2_v_q;
        result_d = result_q;
        err_d    = err_q;
        if (s2_ready) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                result_d = core_result;
                err_d    = core_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_q     <= '0;
            s2_v_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_q     <= s1_d;
            s2_v_q   <= s2_v_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign out_valid = s2_v_q;
    assign o_result  = result_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_stateless_alu_pipe.sv
// Bench for stateless_alu_pipe: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based behavioural model of the two-entry pipeline.
module tb_stateless_alu_pipe;

    localparam int DW  = 32;
    localparam int NP  = 3;
    localparam int SW  = 2;
    localparam int DW2 = 16;
    localparam int NP2 = 5;
    localparam int SW2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [NP*DW-1:0] pkt       = '0;
    logic [DW-1:0]    cons      = '0;
    logic [3:0]       opcode    = '0;
    logic [5*SW-1:0]  sel       = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [DW-1:0]    o_result;
    logic             o_err;

    logic               w_in_valid  = 1'b0;
    logic               w_in_ready;
    logic [NP2*DW2-1:0] w_pkt       = '0;
    logic [DW2-1:0]     w_cons      = '0;
    logic [3:0]         w_opcode    = '0;
    logic [5*SW2-1:0]   w_sel       = '0;
    logic               w_out_valid;
    logic               w_out_ready = 1'b1;
    logic [DW2-1:0]     w_result;
    logic               w_err;

    stateless_alu_pipe #(
        .DATA_W  (DW),
        .NUM_PKT (NP)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pkt       (pkt),
        .cons      (cons),
        .opcode    (opcode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_result  (o_result),
        .o_err     (o_err)
    );

    stateless_alu_pipe #(
        .DATA_W  (DW2),
        .NUM_PKT (NP2)
    ) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .pkt       (w_pkt),
        .cons      (w_cons),
        .opcode    (w_opcode),
        .sel       (w_sel),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .o_result  (w_result),
        .o_err     (w_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain wide arithmetic for any width up to 32.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c1, input logic [31:0] c2,
                                          input logic [31:0] c3, input int op, input int w);
        longint unsigned m, ua, ub, r, half;
        longint sa, sb;
        logic e;
        m    = (64'd1 << w) - 64'd1;
        half = 64'd1 << (w - 1);
        ua   = {32'd0, a} & m;
        ub   = {32'd0, b} & m;
        sa   = (ua >= half) ? longint'(ua) - longint'(m + 64'd1) : longint'(ua);
        sb   = (ub >= half) ? longint'(ub) - longint'(m + 64'd1) : longint'(ub);
        r    = 0;
        e    = 1'b0;
        case (op)
            0:  r = (ua + ub) & m;
            1:  r = (ua + (m + 64'd1) - ub) & m;
            2:  r = ua & ub;
            3:  r = ua ^ ub;
            4:  r = ua | ub;
            5:  r = (ua == ub) ? 1 : 0;
            6:  r = (ua != ub) ? 1 : 0;
            7:  r = (ua >= ub) ? 1 : 0;
            8:  r = (ua < ub) ? 1 : 0;
            9:  r = (ub >= longint'(w)) ? 0 : (ua << ub) & m;
            10: r = (ub >= longint'(w)) ? 0 : ua >> ub;
            11: r = ((({32'd0, c1}) & m) != 0) ? ({32'd0, c2} & m) : ({32'd0, c3} & m);
            12: r = (ua > ub) ? ua : ub;
            13: r = (ua < ub) ? ua : ub;
            14: r = (sa < sb) ? 1 : 0;
            default: begin
                r = 0;
                e = 1'b1;
            end
        endcase
        return {e, r[31:0]};
    endfunction

    function automatic logic [31:0] pick(input int s, input logic [NP*DW-1:0] p,
                                         input logic [DW-1:0] c);
        return (s < NP) ? p[s*DW +: DW] : c;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2:       return 32'h8000_0000 ^ 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    bit   post_rst  = 1'b0;
    bit   prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic        prev_err;
    int   drained   = 0;
    bit   saw_block = 1'b0;
    bit   rand_rdy  = 1'b0;

    // Compare process: inputs change just after posedge, so at negedge every signal
    // shows what the next posedge will act on.
    always @(negedge clk) begin
        logic [32:0] m;
        bit exp_ov;
        cyc++;
        if (!rst_n) begin
            q.delete();
            post_rst   = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (post_rst) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 1);
                check("rst_o_result", o_result, 0);
                check("rst_o_err", o_err, 0);
                post_rst = 1'b0;
            end
            // The oldest entry never waits in stage 1, so it is visible two edges after accept.
            exp_ov = (q.size() > 0) && (cyc - q[0].acc_cyc >= 2);
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, (q.size() < 2) || out_ready);
            if (prev_stall) begin
                check("hold_result", o_result, prev_res);
                check("hold_err", o_err, prev_err);
            end
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    check("result", o_result, q[0].res);
                    check("err", o_err, q[0].err);
                    void'(q.pop_front());
                    drained++;
                end
            end
            if (in_valid && in_ready) begin
                m = model(pick(int'(sel[0*SW +: SW]), pkt, cons),
                          pick(int'(sel[1*SW +: SW]), pkt, cons),
                          pick(int'(sel[2*SW +: SW]), pkt, cons),
                          pick(int'(sel[3*SW +: SW]), pkt, cons),
                          pick(int'(sel[4*SW +: SW]), pkt, cons),
                          int'(opcode), DW);
                q.push_back('{res: m[31:0], err: m[32], acc_cyc: cyc});
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = o_result;
            prev_err   = o_err;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int op, input int sa, input int sb, input int s1,
                        input int s2, input int s3);
        bit got;
        opcode   = 4'(op);
        sel      = {SW'(s3), SW'(s2), SW'(s1), SW'(sb), SW'(sa)};
        in_valid = 1'b1;
        got      = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            idle(1);
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
    endtask

    task automatic send_w(input int op, input int sa, input int sb, input logic [15:0] exp,
                          input string name);
        w_opcode   = 4'(op);
        w_sel      = {SW2'(0), SW2'(0), SW2'(0), SW2'(sb), SW2'(sa)};
        w_in_valid = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, w_in_ready, 1);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({name, "_valid"}, w_out_valid, 1);
        check({name, "_result"}, w_result, exp);
        check({name, "_err"}, w_err, 0);
        idle(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        logic [32:0] m;
        int d0;

        // Pin the model against hand-computed values.
        m = model(7, 5, 0, 0, 0, 0, 32);                  check("m_add", m, 33'd12);
        m = model(1, 32, 0, 0, 0, 9, 32);                 check("m_shl32", m, 33'd0);
        m = model(1, 31, 0, 0, 0, 9, 32);                 check("m_shl31", m, 33'h0_8000_0000);
        m = model(0, 1, 0, 0, 0, 1, 32);                  check("m_sub", m, 33'h0_FFFF_FFFF);
        m = model(32'hFFFF_FFFF, 0, 0, 0, 0, 14, 32);     check("m_slts", m, 33'd1);
        m = model(32'hFFFF_FFFF, 0, 0, 0, 0, 8, 32);      check("m_lt", m, 33'd0);
        m = model(0, 0, 0, 4, 9, 11, 32);                 check("m_cond0", m, 33'd9);
        m = model(0, 0, 2, 4, 9, 11, 32);                 check("m_cond2", m, 33'd4);
        m = model(3, 3, 0, 0, 0, 15, 32);                 check("m_illegal", m, 33'h1_0000_0000);
        m = model(32'hFFFF, 1, 0, 0, 0, 0, 16);           check("m_add16", m, 33'd0);
        m = model(32'hF0, 4, 0, 0, 0, 10, 32);            check("m_shr", m, 33'h0F);

        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;

        // Basic add with latency check: f0=3, f1=7, f2=10, cons=5.
        pkt  = {32'd10, 32'd7, 32'd3};
        cons = 32'd5;
        send(0, 1, 3, 0, 0, 0);
        @(negedge clk);
        check("lat_first_edge", out_valid, 0);
        @(negedge clk);
        check("lat_second_edge", out_valid, 1);
        check("add_result", o_result, 32'd12);
        check("add_err", o_err, 0);
        idle(2);

        // Shift boundaries, wrap-around subtract, signed/unsigned compare.
        pkt = {32'd31, 32'd32, 32'd1};
        send(9, 0, 1, 0, 0, 0);
        send(9, 0, 2, 0, 0, 0);
        send(10, 0, 1, 0, 0, 0);
        pkt = {32'd0, 32'd1, 32'd0};
        send(1, 0, 1, 0, 0, 0);
        pkt = {32'd0, 32'd0, 32'hFFFF_FFFF};
        send(14, 0, 1, 0, 0, 0);
        send(8, 0, 1, 0, 0, 0);
        // Conditional select and the illegal opcode.
        pkt  = {32'd9, 32'd4, 32'd0};
        cons = 32'd2;
        send(11, 0, 0, 0, 1, 2);
        send(11, 0, 0, 3, 1, 2);
        send(15, 1, 2, 0, 0, 0);
        drain_all();

        // Eight back-to-back ops with a four-cycle output stall.
        saw_block = 1'b0;
        d0        = drained;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    pkt  = {rnd32(), rnd32(), rnd32()};
                    cons = rnd32();
                    send($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                end
            end
            begin
                idle(2);
                out_ready = 1'b0;
                idle(4);
                out_ready = 1'b1;
            end
        join
        drain_all();
        check("b2b_blocked", saw_block, 1);
        check("b2b_count", drained - d0, 8);

        // Reset with both stages full; inputs presented during reset are ignored.
        out_ready = 1'b0;
        send(0, 0, 1, 0, 0, 0);
        send(2, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        idle(1);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);

        // Randomized traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            pkt  = {rnd32(), rnd32(), rnd32()};
            cons = rnd32();
            if ($urandom_range(0, 3) == 0) idle(1);
            send($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        rand_rdy = 1'b0;
        idle(1);
        out_ready = 1'b1;
        drain_all();

        // 16-bit, 5-field instance: select 7 routes the constant, select 4 a real field.
        w_pkt  = {16'h1234, 16'h0, 16'h0, 16'h0, 16'h0001};
        w_cons = 16'hFFFF;
        send_w(0, 7, 0, 16'h0000, "w_add_wrap");
        send_w(3, 4, 5, 16'hEDCB, "w_xor_f4");
        send_w(12, 0, 6, 16'hFFFF, "w_max_cons");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
